// File: rtl/adc_test_pkg.sv
// Shared constants and helpers for the synthetic ADC source.
//   DEF_*        default lane geometry and ramp step
//   LFSR_TAPS    feedback tap mask for x^14+x^13+x^12+x^2+1 (bits 13,12,11,1)
//   LFSR_SEED0   seed of lane 0; lane k is seeded with LFSR_SEED0 << k
//   lane_pack    zero-extends one sample into its output lane
//   lfsr_seed    per-lane seed
//   lfsr_next    one Fibonacci LFSR step
package adc_test_pkg;

  localparam int unsigned DEF_LANES    = 4;
  localparam int unsigned DEF_LANE_W   = 16;
  localparam int unsigned DEF_SAMPLE_W = 14;
  localparam int unsigned DEF_STEP     = 1;

  localparam logic [DEF_SAMPLE_W-1:0] LFSR_TAPS  = 14'h3802;
  localparam logic [DEF_SAMPLE_W-1:0] LFSR_SEED0 = 14'h0001;

  // Upper lane bits are always zero.
  function automatic logic [DEF_LANE_W-1:0] lane_pack(input logic [DEF_SAMPLE_W-1:0] s);
    return DEF_LANE_W'(s);
  endfunction

  function automatic logic [DEF_SAMPLE_W-1:0] lfsr_seed(input int unsigned k);
    return LFSR_SEED0 << k;
  endfunction

  // Shift left, feedback bit enters at bit 0.
  function automatic logic [DEF_SAMPLE_W-1:0] lfsr_next(input logic [DEF_SAMPLE_W-1:0] s);
    return {s[DEF_SAMPLE_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/adc_test_rst_sync.sv
// Reset release synchronizer: asynchronous assert, two-edge synchronous release.
//   clk_i   sample clock
//   rst_ni  asynchronous active-low reset
//   run_o   high from the second rising edge after reset release
module adc_test_rst_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic run_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift a one in from the bottom.
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign run_o = sync_q[1];

endmodule

// File: rtl/adc_test.sv
// Synthetic ADC source: one 64-bit word per clock, four zero-extended 14-bit
// samples following a ramp (default) or per-lane LFSR patterns.
//   i_62clk   62.5 MHz sample clock
//   i_nreset  asynchronous active-low reset
//   o_data    registered packed samples, lane k in bits [16k+15:16k]
// Build option: define ADC_TEST_LFSR_EN to replace the ramp by one 14-bit
// Fibonacci LFSR per lane (STEP is then unused).
module adc_test
  import adc_test_pkg::*;
#(
  parameter int unsigned STEP = DEF_STEP
) (
  input  logic        i_62clk,
  input  logic        i_nreset,
  output logic [63:0] o_data
);

  localparam int unsigned LANES    = DEF_LANES;
  localparam int unsigned LANE_W   = DEF_LANE_W;
  localparam int unsigned SAMPLE_W = DEF_SAMPLE_W;

  logic                         run;
  logic [LANES-1:0][LANE_W-1:0] data_d;
  logic [LANES-1:0][LANE_W-1:0] data_q;

  adc_test_rst_sync u_rst_sync (
    .clk_i  (i_62clk),
    .rst_ni (i_nreset),
    .run_o  (run)
  );

`ifndef ADC_TEST_LFSR_EN
  // Ramp base: first sample of the next word; wraps silently.
  logic [SAMPLE_W-1:0] base_q;
  logic [SAMPLE_W-1:0] base_d;

  always_comb begin
    base_d = base_q;
    if (run) begin
      base_d = base_q + SAMPLE_W'(LANES * STEP);
    end
  end

  always_ff @(posedge i_62clk or negedge i_nreset) begin
    if (!i_nreset) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end
`endif

  // Per-lane sample generation.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef ADC_TEST_LFSR_EN
    logic [SAMPLE_W-1:0] lfsr_q;
    logic [SAMPLE_W-1:0] lfsr_d;

    // The current state is emitted, then advanced, so the first word holds the seeds.
    always_comb begin
      lfsr_d = lfsr_q;
      if (run) begin
        lfsr_d = lfsr_next(lfsr_q);
      end
    end

    always_ff @(posedge i_62clk or negedge i_nreset) begin
      if (!i_nreset) begin
        lfsr_q <= lfsr_seed(k);
      end else begin
        lfsr_q <= lfsr_d;
      end
    end

    assign data_d[k] = run ? lane_pack(lfsr_q) : '0;
`else
    assign data_d[k] = run ? lane_pack(base_q + SAMPLE_W'(k * STEP)) : '0;
`endif
  end

  // Output register, cleared asynchronously so reset shows without a clock.
  always_ff @(posedge i_62clk or negedge i_nreset) begin
    if (!i_nreset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_adc_test.sv
// Directed self-checking bench for adc_test (ramp build by default,
// LFSR expectations when ADC_TEST_LFSR_EN is defined).
module tb_adc_test;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [13:0] m [4];

`ifdef ADC_TEST_LFSR_EN
  localparam logic [63:0] FIRST_WORD  = 64'h0008_0004_0002_0001;
  localparam logic [63:0] SECOND_WORD = 64'h0010_0008_0005_0002;
`else
  localparam logic [63:0] FIRST_WORD  = 64'h0003_0002_0001_0000;
  localparam logic [63:0] SECOND_WORD = 64'h0007_0006_0005_0004;
`endif

  always #8 clk = ~clk;

  adc_test dut (
    .i_62clk  (clk),
    .i_nreset (rst_n),
    .o_data   (data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
`ifdef ADC_TEST_LFSR_EN
      m[k] = 14'(1 << k);
`else
      m[k] = 14'(k);
`endif
    end
  endtask

  task automatic model_adv();
    for (int k = 0; k < 4; k++) begin
`ifdef ADC_TEST_LFSR_EN
      m[k] = {m[k][12:0], m[k][13] ^ m[k][12] ^ m[k][11] ^ m[k][1]};
`else
      m[k] = m[k] + 14'd4;
`endif
    end
  endtask

  function automatic logic [63:0] model_word();
    logic [63:0] w;
    for (int k = 0; k < 4; k++) begin
      w[16*k +: 16] = {2'b00, m[k]};
    end
    return w;
  endfunction

  // Edges 1-2 after release stay zero, edge 3 shows the first word.
  task automatic latency_seq(input string tag);
    edge_step();
    check({tag, "_e1"}, data, 64'h0);
    edge_step();
    check({tag, "_e2"}, data, 64'h0);
    edge_step();
    check({tag, "_e3"}, data, FIRST_WORD);
    model_reset();
  endtask

  task automatic run_words(input string tag, input int count);
    for (int n = 1; n <= count; n++) begin
      edge_step();
      model_adv();
      check(tag, data, model_word());
      if (n % 1000 == 0) begin
        check({tag, "_upper"}, data & 64'hC000_C000_C000_C000, 64'h0);
      end
    end
  endtask

  initial begin
    // Reset held from time zero: output already clear before any edge.
    #3;
    check("reset_pre_edge", data, 64'h0);
    repeat (3) begin
      edge_step();
      check("reset_hold", data, 64'h0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    latency_seq("rel");
    edge_step();
    model_adv();
    check("word1", data, SECOND_WORD);

`ifdef ADC_TEST_LFSR_EN
    // Lane 0 must return to its seed after 16383 steps and never read zero.
    for (int n = 2; n <= 16384; n++) begin
      edge_step();
      model_adv();
      check("lfsr", data, model_word());
      check("lane0_nz", 64'(data[15:0] != 16'h0), 64'h1);
      if (n == 16383) begin
        check("lfsr_period", 64'(data[15:0]), 64'h1);
      end
    end
`else
    // Wrap of the 14-bit ramp.
    for (int n = 2; n <= 4096; n++) begin
      edge_step();
      model_adv();
      if (n == 4095) begin
        check("w4095", data, 64'h3FFF_3FFE_3FFD_3FFC);
      end else if (n == 4096) begin
        check("w4096", data, 64'h0003_0002_0001_0000);
      end else begin
        check("ramp", data, model_word());
      end
    end
`endif

    // Mid-run reset: cleared immediately, held ~300, restart with full latency.
    run_words("pre_mid", 60);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check("mid_async_clr", data, 64'h0);
    repeat (19) begin
      edge_step();
      check("mid_hold", data, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    latency_seq("mid_rel");
    run_words("post_mid", 20);

    // Sub-cycle reset pulse between edges still restarts the sequence.
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
    check("pulse_clr", data, 64'h0);
    latency_seq("pulse");
    check("pulse_model", data, model_word());

    // Long run against the model, lane upper bits sampled periodically.
    run_words("long", 10000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
